pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage RISC-V merge-sort pipeline. It drives write-enables, flushes and bubbles for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It generates forwarding selects for the EX-stage ALU operands. It handles four cases: load-use stalls, taken-branch flushes, multi-cycle data-memory waits, and a watchdog halt on a memory that never responds.

---
 rtl/pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes, memory-wait freeze, watchdog halt, forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_EscReg,
    input  logic       ex_lw,
    input  logic       ex_branch_taken,
    input  logic [4:0] mem_rd,
    input  logic       mem_EscReg,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic [4:0] wb_rd,
    input  logic       wb_EscReg,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       id_ex_we,
    output logic       ex_mem_we,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_wb_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_lu_stalls
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(MEM_TIMEOUT);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             lu_s, run_act_s, branch_evt_s, lu_evt_s;

    // Forwarding: the younger producer (EX_MEM) wins over MEM_WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic m_we, input logic [4:0] m_rd,
                                           input logic w_we, input logic [4:0] w_rd);
        logic [1:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign fwd_a = reset ? fwd_sel(ex_rs1, mem_EscReg, mem_rd, wb_EscReg, wb_rd) : 2'b00;
    assign fwd_b = reset ? fwd_sel(ex_rs2, mem_EscReg, mem_rd, wb_EscReg, wb_rd) : 2'b00;

    assign lu_s = ex_lw && ex_EscReg && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    assign cnt_inc_s = (cnt_r != CNT_MAX) ? (cnt_r + CNT_ONE) : CNT_MAX;
    assign state     = state_r;

    // Next-state, wait counter and pipeline control outputs.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        run_act_s     = 1'b0;
        branch_evt_s  = 1'b0;
        lu_evt_s      = 1'b0;
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b1;
        halted        = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = (MEM_TIMEOUT == 1) ? ST_HALT : ST_MEM_WAIT;
                end else begin
                    run_act_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    run_act_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    if (cnt_inc_s == CNT_TO) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_MEM_WAIT;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        // A taken branch overrides a simultaneous load-use match.
        if (run_act_s) begin
            mem_wb_bubble = 1'b0;
            if (ex_branch_taken) begin
                {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                branch_evt_s = 1'b1;
            end else if (lu_s) begin
                {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0011;
                id_ex_flush = 1'b1;
                lu_evt_s    = 1'b1;
            end else begin
                {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
            end
        end else begin
            mem_wb_bubble = 1'b1;
        end

        if (!reset) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
            halted        = 1'b0;
            branch_evt_s  = 1'b0;
            lu_evt_s      = 1'b0;
        end else begin
            halted = (state_r == ST_HALT);
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
            perf_lu_stalls    <= 32'd0;
        end else begin
            if (!pc_we && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end else begin
                perf_stall_cycles <= perf_stall_cycles;
            end
            if (branch_evt_s && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end else begin
                perf_flushes <= perf_flushes;
            end
            if (lu_evt_s && (perf_lu_stalls != 32'hFFFF_FFFF)) begin
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            end else begin
                perf_lu_stalls <= perf_lu_stalls;
            end
        end
    end
`endif

endmodule
